dram_model: RTL and testbench

- Cycle-accurate, synthesizable-for-simulation DRAM device. It is the pin-level responder to the DRAM command bus (CSn/RASn/CASn/WEn/A/D) driven by the system's DRAM AXI slave wrapper.
- Decodes activate, column read, column write and precharge. Holds one open row and returns read data after a fixed CAS latency with a one-cycle valid strobe.
- Used in the top-level testbench and in system simulation in place of the external DRAM.

---
 rtl/dram_model.sv | 156 +++++++++++++++
 tb/tb_dram_model.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_model.sv
// Cycle-accurate DRAM device model: one open row, CAS-latency read pipeline, sticky ERR.
// Optional activate/precharge timing checks are enabled with `define DRAM_TIMING_CHECK_EN.
module dram_model #(
   parameter int ROW_BITS = 11,
   parameter int COL_BITS = 10,
   parameter int CAS_LAT  = 5,
   parameter int T_RCD    = 4,
   parameter int T_RP     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CSn,
   input  logic        RASn,
   input  logic        CASn,
   input  logic [3:0]  WEn,
   input  logic [10:0] A,
   input  logic [31:0] D,
   output logic [31:0] Q,
   output logic        VALID,
   output logic        ERR
);

   localparam int ADDR_W = ROW_BITS + COL_BITS;
   localparam int DEPTH  = 1 << ADDR_W;

   if (CAS_LAT < 1 || CAS_LAT > 8 || T_RCD < 1 || T_RP < 1) begin : g_bad_param
      $error("dram_model: illegal CAS_LAT/T_RCD/T_RP");
   end

   typedef enum logic {CLOSED, OPEN} row_state_t;

   row_state_t          state_q, state_d;
   logic                row_open;
   logic [ROW_BITS-1:0] row_q;
   logic [ADDR_W-1:0]   word_addr;
   logic [31:0]         mem [DEPTH];

   logic                pipe_valid [CAS_LAT];
   logic [31:0]         pipe_data  [CAS_LAT];

   logic cmd_row, cmd_col, cmd_bad;
   logic act_req, act_ok, pre_ok, col_req, timing_ok;
   logic rd_ok, wr_ok, err_set;

`ifdef DRAM_TIMING_CHECK_EN
   localparam int CNT_W = $clog2((T_RCD > T_RP ? T_RCD : T_RP) + 1);
   logic [CNT_W-1:0] act_cnt, pre_cnt;
   logic             pre_seen;

   // Counters saturate at their limit; a value of k means the command edge is k edges later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_cnt  <= '0;
         pre_cnt  <= '0;
         pre_seen <= 1'b0;
      end else begin
         if (act_ok)
            act_cnt <= CNT_W'(1);
         else if (act_cnt < CNT_W'(T_RCD))
            act_cnt <= act_cnt + CNT_W'(1);
         if (pre_ok) begin
            pre_cnt  <= CNT_W'(1);
            pre_seen <= 1'b1;
         end else if (pre_cnt < CNT_W'(T_RP)) begin
            pre_cnt <= pre_cnt + CNT_W'(1);
         end
      end
   end
`endif

   always_comb begin
      cmd_row   = !CSn && !RASn &&  CASn;
      cmd_col   = !CSn &&  RASn && !CASn;
      cmd_bad   = !CSn && !RASn && !CASn;
      act_req   = cmd_row && !row_open;
      pre_ok    = cmd_row &&  row_open;
      col_req   = cmd_col &&  row_open;
`ifdef DRAM_TIMING_CHECK_EN
      act_ok    = act_req && (!pre_seen || pre_cnt >= CNT_W'(T_RP));
      timing_ok = act_cnt >= CNT_W'(T_RCD);
`else
      act_ok    = act_req;
      timing_ok = 1'b1;
`endif
      rd_ok     = col_req && timing_ok && (WEn == 4'hF);
      wr_ok     = col_req && timing_ok && (WEn != 4'hF);
      err_set   = cmd_bad || (cmd_col && !row_open) ||
                  (act_req && !act_ok) || (col_req && !timing_ok);
      word_addr = {row_q, A[COL_BITS-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= CLOSED;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLOSED:  if (act_ok) state_d = OPEN;
         OPEN:    if (pre_ok) state_d = CLOSED;
         default: state_d = CLOSED;
      endcase
   end

   always_comb begin
      row_open = (state_q == OPEN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         ERR   <= 1'b0;
      end else begin
         if (act_ok)
            row_q <= A[ROW_BITS-1:0];
         if (err_set)
            ERR <= 1'b1;
      end
   end

   // The array has no reset so it behaves like real DRAM contents across rst.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (!WEn[i])
               mem[word_addr][8*i +: 8] <= D[8*i +: 8];
         end
      end
   end

   // Stage 0 samples the array at the READ edge; the output register adds the final edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CAS_LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_data[i]  <= '0;
         end
         VALID <= 1'b0;
         Q     <= '0;
      end else begin
         pipe_valid[0] <= rd_ok;
         pipe_data[0]  <= mem[word_addr];
         for (int i = 1; i < CAS_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
         VALID <= pipe_valid[CAS_LAT-1];
         if (pipe_valid[CAS_LAT-1])
            Q <= pipe_data[CAS_LAT-1];
      end
   end

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: a vector table for the main flow plus hand sequences
// for error, reset-during-read and activate-to-column timing cases.
module tb_dram_model;

   logic        clk = 1'b0;
   logic        rst;
   logic        CSn, RASn, CASn;
   logic [3:0]  WEn;
   logic [10:0] A;
   logic [31:0] D;
   logic [31:0] Q;
   logic        VALID, ERR;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string       name;
      logic        csn, rasn, casn;
      logic [3:0]  wen;
      logic [10:0] a;
      logic [31:0] d;
      logic        exp_valid;
      logic        chk_q;
      logic [31:0] exp_q;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   dram_model dut (
      .clk   (clk),
      .rst   (rst),
      .CSn   (CSn),
      .RASn  (RASn),
      .CASn  (CASn),
      .WEn   (WEn),
      .A     (A),
      .D     (D),
      .Q     (Q),
      .VALID (VALID),
      .ERR   (ERR)
   );

   always #5 clk = ~clk;

   // Drive one command for one cycle, then return just after the rising edge that decodes it.
   task automatic applyStimulus(input logic csn, input logic rasn, input logic casn,
                                input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic exp_valid, input logic chk_q,
                              input logic [31:0] exp_q, input logic exp_err);
      tests_run++;
      if (VALID !== exp_valid || ERR !== exp_err || (chk_q && Q !== exp_q)) begin
         tests_failed++;
         $display("[TB] FAIL %s: VALID=%b ERR=%b Q=%h, required VALID=%b ERR=%b Q=%h%s",
                  name, VALID, ERR, Q, exp_valid, exp_err, exp_q, chk_q ? "" : " (Q not checked)");
      end
   endtask

   task automatic nop();
      applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic void addVec(input string name, input logic csn, input logic rasn,
                                  input logic casn, input logic [3:0] wen, input logic [10:0] a,
                                  input logic [31:0] d, input logic exp_valid, input logic chk_q,
                                  input logic [31:0] exp_q);
      vec_t v;
      v.name = name; v.csn = csn; v.rasn = rasn; v.casn = casn; v.wen = wen;
      v.a = a; v.d = d; v.exp_valid = exp_valid; v.chk_q = chk_q; v.exp_q = exp_q;
      v.exp_err = 1'b0;
      vecs.push_back(v);
   endfunction

   initial begin
      rst = 1'b1;
      CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Main flow: activate, full/partial writes, reads at CAS latency 5, burst + precharge.
      addVec("act_row12",  0, 0, 1, 4'hF, 11'h012, 32'h0, 0, 1, 32'h0);
      addVec("nop1",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("nop2",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("nop3",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("wr_full",    0, 1, 0, 4'h0, 11'h005, 32'hDEADBEEF, 0, 0, 32'h0);
      addVec("rd_full",    0, 1, 0, 4'hF, 11'h005, 32'h0, 0, 0, 32'h0);
      addVec("lat1",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("lat2",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("lat3",       1, 0, 0, 4'h0, 11'h005, 32'h0, 0, 0, 32'h0);
      addVec("lat4",       0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("lat5_data",  0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hDEADBEEF);
      addVec("wr_partial", 0, 1, 0, 4'b1010, 11'h005, 32'h11223344, 0, 1, 32'hDEADBEEF);
      addVec("rd_partial", 0, 1, 0, 4'hF, 11'h005, 32'h0, 0, 1, 32'hDEADBEEF);
      addVec("plat1",      0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("plat2",      0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("plat3",      0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("plat4",      0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("plat5_data", 0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hDE22BE44);
      addVec("pre_col0",   0, 1, 0, 4'h0, 11'h000, 32'hA0, 0, 1, 32'hDE22BE44);
      addVec("pre_col1",   0, 1, 0, 4'h0, 11'h001, 32'hA1, 0, 0, 32'h0);
      addVec("pre_col2",   0, 1, 0, 4'h0, 11'h002, 32'hA2, 0, 0, 32'h0);
      addVec("pre_col3",   0, 1, 0, 4'h0, 11'h003, 32'hA3, 0, 0, 32'h0);
      addVec("burst_rd0",  0, 1, 0, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("burst_rd1",  0, 1, 0, 4'hF, 11'h001, 32'h0, 0, 0, 32'h0);
      addVec("burst_rd2",  0, 1, 0, 4'hF, 11'h002, 32'h0, 0, 0, 32'h0);
      addVec("burst_rd3",  0, 1, 0, 4'hF, 11'h003, 32'h0, 0, 0, 32'h0);
      addVec("precharge",  0, 0, 1, 4'hF, 11'h000, 32'h0, 0, 0, 32'h0);
      addVec("burst_q0",   0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hA0);
      addVec("burst_q1",   0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hA1);
      addVec("burst_q2",   0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hA2);
      addVec("burst_q3",   0, 1, 1, 4'hF, 11'h000, 32'h0, 1, 1, 32'hA3);
      addVec("q_hold",     0, 1, 1, 4'hF, 11'h000, 32'h0, 0, 1, 32'hA3);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].csn, vecs[i].rasn, vecs[i].casn, vecs[i].wen, vecs[i].a, vecs[i].d);
         checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].chk_q, vecs[i].exp_q, vecs[i].exp_err);
      end

      // Illegal commands: column access while closed, RAS+CAS together while open.
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 11'h005, 32'h0);
      checkOutput("cas_closed_err", 1'b0, 1'b1, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         nop();
         checkOutput("cas_closed_novalid", 1'b0, 1'b0, 32'h0, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 11'h012, 32'h0);
      checkOutput("err_sticky_act", 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) nop();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 11'h005, 32'h0);
      checkOutput("ras_cas_err", 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 11'h005, 32'h0);
      repeat (4) nop();
      checkOutput("still_open_pre", 1'b0, 1'b0, 32'h0, 1'b1);
      nop();
      checkOutput("mem_unchanged", 1'b1, 1'b1, 32'hDE22BE44, 1'b1);

      // Reset while a read is in flight.
      doReset();
      checkOutput("err_cleared", 1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 11'h012, 32'h0);
      repeat (3) nop();
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
      repeat (2) nop();
      rst = 1'b1;
      #1;
      checkOutput("midread_reset", 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         nop();
         checkOutput("dropped_read", 1'b0, 1'b1, 32'h0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 11'h000, 32'h0);
      checkOutput("closed_after_rst", 1'b0, 1'b1, 32'h0, 1'b1);

      // Column read only two edges after activate.
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 11'h012, 32'h0);
      nop();
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
`ifdef DRAM_TIMING_CHECK_EN
      checkOutput("early_rd_err", 1'b0, 1'b1, 32'h0, 1'b1);
      repeat (5) nop();
      checkOutput("early_rd_dropped", 1'b0, 1'b1, 32'h0, 1'b1);
`else
      checkOutput("early_rd_ok", 1'b0, 1'b1, 32'h0, 1'b0);
      repeat (5) nop();
      checkOutput("early_rd_data", 1'b1, 1'b1, 32'hA1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
